// File: rtl/axil_reg_file.sv
// rtl/axil_reg_file.sv - AXI-Lite slave register file with read-only mask and write strobes
// Independent write (AW/W buffered) and read FSMs; byte-strobed updates, SLVERR on bad targets.
module axil_reg_file #(
  parameter int                     ADDR_WIDTH = 32,
  parameter int                     DATA_WIDTH = 32,
  parameter int                     NUM_REGS   = 16,
  parameter logic [NUM_REGS-1:0]    RO_MASK    = '0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           awvalid,
  output logic                           awready,
  input  logic [ADDR_WIDTH-1:0]          awaddr,
  input  logic [2:0]                     awprot,
  input  logic                           wvalid,
  output logic                           wready,
  input  logic [DATA_WIDTH-1:0]          wdata,
  input  logic [DATA_WIDTH/8-1:0]        wstrb,
  output logic                           bvalid,
  output logic [1:0]                     bresp,
  input  logic                           bready,
  input  logic                           arvalid,
  output logic                           arready,
  input  logic [ADDR_WIDTH-1:0]          araddr,
  input  logic [2:0]                     arprot,
  output logic                           rvalid,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic [1:0]                     rresp,
  input  logic                           rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_o,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] reg_i,
  output logic [NUM_REGS-1:0]            wr_pulse
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int IW     = $clog2(NUM_REGS);
  localparam int BB     = $clog2(STRB_W);
  localparam int SPAN   = NUM_REGS * STRB_W;

  localparam logic [0:0] W_IDLE = 1'b0;
  localparam logic [0:0] W_RESP = 1'b1;
  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_RESP = 1'b1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [0:0]            wstate;
  logic [0:0]            rstate;
  logic                  ready_en;

  logic                  aw_full;
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic                  w_full;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [STRB_W-1:0]     w_strb_q;

  logic                  aw_hs, w_hs, ar_hs, wr_go;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [STRB_W-1:0]     wr_strb;
  logic [IW-1:0]         wr_idx, rd_idx;
  logic                  wr_oor, rd_oor, wr_ok;
  logic                  unused_prot;

  assign unused_prot = ^{awprot, arprot};

  // Readies come from a flop so they rise only on the first edge after reset release.
  assign awready = ready_en && !aw_full && (wstate == W_IDLE);
  assign wready  = ready_en && !w_full  && (wstate == W_IDLE);
  assign arready = ready_en && (rstate == R_IDLE);
  assign bvalid  = (wstate == W_RESP);
  assign rvalid  = (rstate == R_RESP);

  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid  && wready;
  assign ar_hs = arvalid && arready;

  // A beat arriving on the same edge as the buffered partner completes the pair.
  assign wr_addr = aw_full ? aw_addr_q : awaddr;
  assign wr_data = w_full  ? w_data_q  : wdata;
  assign wr_strb = w_full  ? w_strb_q  : wstrb;
  assign wr_go   = (wstate == W_IDLE) && (aw_full || aw_hs) && (w_full || w_hs);

  assign wr_idx = wr_addr[BB +: IW];
  assign rd_idx = araddr[BB +: IW];
  assign wr_oor = 64'(wr_addr) >= 64'(SPAN);
  assign rd_oor = 64'(araddr)  >= 64'(SPAN);
  assign wr_ok  = !wr_oor && !RO_MASK[wr_idx];

  for (genvar n = 0; n < NUM_REGS; n++) begin : g_reg_o
    assign reg_o[n*DATA_WIDTH +: DATA_WIDTH] = regs[n];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ready_en <= 1'b0;
    else        ready_en <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wstate    <= W_IDLE;
      aw_full   <= 1'b0;
      aw_addr_q <= '0;
      w_full    <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bresp     <= RESP_OKAY;
      wr_pulse  <= '0;
      for (int n = 0; n < NUM_REGS; n++) regs[n] <= '0;
    end else begin
      wr_pulse <= '0;
      case (wstate)
        W_IDLE: begin
          if (wr_go) begin
            wstate  <= W_RESP;
            aw_full <= 1'b0;
            w_full  <= 1'b0;
            bresp   <= wr_ok ? RESP_OKAY : RESP_SLVERR;
            if (wr_ok) begin
              wr_pulse[wr_idx] <= 1'b1;
              for (int k = 0; k < STRB_W; k++)
                if (wr_strb[k]) regs[wr_idx][8*k +: 8] <= wr_data[8*k +: 8];
            end
          end else begin
            if (aw_hs) begin
              aw_full   <= 1'b1;
              aw_addr_q <= awaddr;
            end
            if (w_hs) begin
              w_full   <= 1'b1;
              w_data_q <= wdata;
              w_strb_q <= wstrb;
            end
          end
        end
        default: begin
          if (bready) wstate <= W_IDLE;
        end
      endcase
    end
  end

  // Read data is captured at the AR edge, so a same-edge write is not visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rstate <= R_IDLE;
      rdata  <= '0;
      rresp  <= RESP_OKAY;
    end else begin
      case (rstate)
        R_IDLE: begin
          if (ar_hs) begin
            rstate <= R_RESP;
            if (rd_oor) begin
              rdata <= '0;
              rresp <= RESP_SLVERR;
            end else begin
              rdata <= RO_MASK[rd_idx] ? reg_i[rd_idx*DATA_WIDTH +: DATA_WIDTH] : regs[rd_idx];
              rresp <= RESP_OKAY;
            end
          end
        end
        default: begin
          if (rready) rstate <= R_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/axil_reg_file.md
AXIL_REG_FILE -- requirements
Module: axil_reg_file

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, AXI-Lite address width in bits.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width; legal values 32, 64.
REQ-003 SHALL have parameter NUM_REGS, default 16, register count; power of two, 2..256.
REQ-004 SHALL have parameter RO_MASK, default 0, NUM_REGS-bit mask; bit n set = register n read-only.
REQ-005 SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have ports awvalid/awready/awaddr[ADDR_WIDTH]/awprot[3], with awready as output and the rest as inputs: write address channel.
REQ-008 SHALL have ports wvalid/wready/wdata[DATA_WIDTH]/wstrb[DATA_WIDTH/8], with wready as output and the rest as inputs: write data channel.
REQ-009 SHALL have ports bvalid/bresp[2] (outputs) and bready (input): write response channel.
REQ-010 SHALL have ports arvalid/arready/araddr[ADDR_WIDTH]/arprot[3], with arready as output and the rest as inputs: read address channel.
REQ-011 SHALL have ports rvalid/rdata[DATA_WIDTH]/rresp[2] (outputs) and rready (input): read data channel.
REQ-012 SHALL have port reg_o, output, NUM_REGS*DATA_WIDTH, flattened register contents, register n at bits [n*DATA_WIDTH +: DATA_WIDTH].
REQ-013 SHALL have port reg_i, input, NUM_REGS*DATA_WIDTH, hardware values returned on reads of read-only registers.
REQ-014 SHALL have port wr_pulse, output, NUM_REGS, one-cycle strobe per register on a successful write.

Function
REQ-015 SHALL decode index = addr[BB +: log2(NUM_REGS)], with BB = log2(DATA_WIDTH/8); the low BB address bits are ignored.
REQ-016 SHALL treat an address >= NUM_REGS*DATA_WIDTH/8 as out of range; awprot and arprot are ignored.
REQ-017 SHALL accept AW and W independently in any order, each held in its own one-entry buffer; awready = rst_n and AW buffer empty and write FSM in W_IDLE; wready likewise for the W buffer.
REQ-018 SHALL run a write FSM with states W_IDLE and W_RESP: W_IDLE -> W_RESP on the edge where both buffers are full (same-cycle handshakes count); W_RESP -> W_IDLE on bvalid && bready.
REQ-019 SHALL perform the register update on the W_IDLE->W_RESP edge, asserting bvalid from that edge (write latency 1 cycle after the later of AW/W handshake) and clearing both buffers.
REQ-020 SHALL update byte k of the target register only where wstrb[k]=1; wstrb=0 is a legal no-change write returning OKAY and pulsing wr_pulse.
REQ-021 SHALL respond bresp=SLVERR (2'b10) with no state change and no wr_pulse for an out-of-range or read-only target; otherwise bresp=OKAY (2'b00).
REQ-022 SHALL assert wr_pulse[n] for exactly the one cycle following the update edge of a successful write to register n.
REQ-023 SHALL hold bvalid and bresp stable until bready; AW/W accepted during W_RESP are not permitted (ready low).
REQ-024 SHALL run a read FSM with states R_IDLE and R_RESP: arready = rst_n and state R_IDLE; on the AR handshake, rdata/rresp are registered and the FSM enters R_RESP with rvalid=1 the next cycle; R_RESP -> R_IDLE on rready.
REQ-025 SHALL return the register value for read-write registers, reg_i slice for read-only registers, and rdata=0 with rresp=SLVERR for out-of-range addresses.
REQ-026 SHALL sample read data at the AR handshake edge, so a read and write to the same register on the same edge returns the pre-write value.
REQ-027 SHALL operate the read and write paths fully independently, with no mutual stalling.
REQ-028 SHALL hold rvalid, rdata, and rresp stable until rready.

Reset
REQ-029 SHALL, while rst_n=0, asynchronously force all registers to 0, both buffers empty, both FSMs to IDLE, and awready/wready/arready/bvalid/rvalid/wr_pulse=0, bresp/rresp=00, rdata=0.
REQ-030 SHALL, on reset asserted mid-transaction, discard the transaction without issuing a response after release; ready signals rise on the first clk edge after rst_n=1.

Verification
REQ-031 SHALL verify: AW to 0x04 and W 0xDEADBEEF with strb 0xF in the same cycle -> bvalid 1 cycle later, bresp=00, reg_o[1]=0xDEADBEEF, wr_pulse=0x0002 for one cycle.
REQ-032 SHALL verify: W (0x12345678, strb 0x3) three cycles before AW 0x08 onto reg 2 = 0xAABBCCDD -> reg 2=0xAABB5678, bresp=00.
REQ-033 SHALL verify: write to 0x40 with NUM_REGS=16 -> bresp=10, no reg_o change; read of 0x40 -> rdata=0, rresp=10.
REQ-034 SHALL verify: RO_MASK bit 3 set, reg_i[3]=0xCAFE0000 -> read 0x0C returns 0xCAFE0000/OKAY; write 0x0C -> SLVERR, wr_pulse stays 0.
REQ-035 SHALL verify: bready and rready held low for 10 cycles -> bvalid/rvalid, bresp/rresp, and rdata stable, with awready/wready/arready low throughout.
REQ-036 SHALL verify: rst_n pulsed low while bvalid=1 -> bvalid drops immediately, all reg_o=0, and no response after release.
